// File: rtl/keypad_pkg.sv
// keypad_pkg: state type, hex keymap and bit-count helper shared by the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} kp_state_t;

    // KEY_MAP[row][col], rows top-down, columns left-right
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        popcount16 = '0;
        for (int i = 0; i < 16; i++)
            popcount16 = popcount16 + {4'd0, v[i]};
    endfunction

endpackage

// File: rtl/kp_col_scanner.sv
// kp_col_scanner: drives one column low at a time, synchronizes the rows and assembles a 16-bit pressed map per frame
module kp_col_scanner #(
    parameter int COL_SETTLE_CYC = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] map,
    output logic        map_valid
);

    localparam int CW = $clog2(COL_SETTLE_CYC);
    localparam logic [CW-1:0] LAST = CW'(COL_SETTLE_CYC - 1);

    logic [3:0]    row_meta, row_sync;
    logic [CW-1:0] settle_cnt;
    logic [1:0]    col_idx;
    logic          terminal;

    assign terminal = settle_cnt == LAST;

    // map bit index is col*4 + row; map_valid fires the cycle after the col3 capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta   <= 4'hF;
            row_sync   <= 4'hF;
            settle_cnt <= '0;
            col_idx    <= '0;
            col        <= 4'b1110;
            map        <= '0;
            map_valid  <= 1'b0;
        end else begin
            row_meta  <= row;
            row_sync  <= row_meta;
            map_valid <= terminal && col_idx == 2'd3;
            if (terminal) begin
                settle_cnt                <= '0;
                map[{col_idx, 2'b00} +: 4] <= ~row_sync;
                col_idx                   <= col_idx + 2'd1;
                col                       <= {col[2:0], col[3]};
            end else begin
                settle_cnt <= settle_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: classifies each scanned frame and debounces presses/releases across whole frames
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int COL_SETTLE_CYC = 5000,
    parameter int STABLE_SCANS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_press,
    output logic       key_release,
    output logic       multi_key,
    output logic       frame_done
);

    localparam int SW = $clog2(STABLE_SCANS + 1);
    localparam logic [SW-1:0] LAST = SW'(STABLE_SCANS);

    logic [15:0]   map;
    logic          map_valid;
    kp_state_t     state;
    logic [SW-1:0] stable_cnt, next_cnt;
    logic [3:0]    cand, idx;
    logic [4:0]    ones;
    logic          single, multi, held_bit, run_done;

    kp_col_scanner #(.COL_SETTLE_CYC(COL_SETTLE_CYC)) u_scan (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .map       (map),
        .map_valid (map_valid)
    );

    always_comb begin
        idx = '0;
        for (int i = 0; i < 16; i++)
            if (map[i]) idx = 4'(i);
    end

    assign ones     = popcount16(map);
    assign single   = ones == 5'd1;
    assign multi    = ones > 5'd1;
    assign held_bit = map[cand];
    assign next_cnt = stable_cnt + SW'(1);
    assign run_done = next_cnt == LAST;

    // cand doubles as the held key's map index while in HELD/REL_PEND
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            stable_cnt  <= '0;
            cand        <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            multi_key   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done  <= map_valid;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (map_valid) begin
                multi_key <= multi;
                case (state)
                    IDLE: if (single) begin
                        cand       <= idx;
                        stable_cnt <= SW'(1);
                        state      <= PRESS_PEND;
                    end
                    PRESS_PEND: if (!single) begin
                        state <= IDLE;
                    end else if (idx != cand) begin
                        cand       <= idx;
                        stable_cnt <= SW'(1);
                    end else begin
                        stable_cnt <= next_cnt;
                        if (run_done) begin
                            key_code  <= KEY_MAP[cand[1:0]][cand[3:2]];
                            key_valid <= 1'b1;
                            key_press <= 1'b1;
                            state     <= HELD;
                        end
                    end
                    HELD: if (!held_bit) begin
                        stable_cnt <= SW'(1);
                        state      <= REL_PEND;
                    end
                    REL_PEND: if (held_bit) begin
                        state <= HELD;
                    end else begin
                        stable_cnt <= next_cnt;
                        if (run_done) begin
                            key_valid   <= 1'b0;
                            key_release <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-level reference model of the debounced keypad, directed plus random key patterns
module tb_keypad_scanner;

    localparam int CS = 4;
    localparam int S  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keys;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_press, key_release, multi_key, frame_done;

    int checks = 0, errors = 0;
    int press_seen = 0, rel_seen = 0, bad_pulse = 0;
    int exp_press = 0, exp_rel = 0;

    logic [15:0] hist[$];
    bit          mheld;
    logic [3:0]  mcode, midx;
    logic [3:0]  km [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

    keypad_scanner #(.COL_SETTLE_CYC(CS), .STABLE_SCANS(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_press   (key_press),
        .key_release (key_release),
        .multi_key   (multi_key),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // physical keypad: a pressed key shorts its row to its column
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) if (!rst) begin
        if (key_press) press_seen++;
        if (key_release) rel_seen++;
        if ((key_press || key_release) && !frame_done) bad_pulse++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] kb(input int r, input int c);
        return 16'(1) << (c*4 + r);
    endfunction

    function automatic logic [3:0] low_idx(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return 4'(i);
        return 4'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        mheld = 0;
        mcode = 4'h0;
        midx  = 4'h0;
    endtask

    task automatic step(input logic [15:0] m);
        int n = 0;
        bit ok, p, r;
        logic [15:0] k;
        keys = m;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        chk("frame_done", frame_done, 1);
        hist.push_back(m);
        p = 0;
        r = 0;
        if (!mheld && hist.size() >= S) begin
            k  = hist[hist.size()-1];
            ok = $countones(k) == 1;
            for (int i = 1; i < S; i++) if (hist[hist.size()-1-i] !== k) ok = 0;
            if (ok) begin
                p     = 1;
                mheld = 1;
                midx  = low_idx(k);
                mcode = km[{midx[1:0], midx[3:2]}];
                hist.delete();
            end
        end else if (mheld && hist.size() >= S) begin
            ok = 1;
            for (int i = 0; i < S; i++) if (hist[hist.size()-1-i][midx]) ok = 0;
            if (ok) begin
                r     = 1;
                mheld = 0;
                hist.delete();
            end
        end
        exp_press += int'(p);
        exp_rel   += int'(r);
        chk("key_press", key_press, p);
        chk("key_release", key_release, r);
        chk("key_valid", key_valid, mheld);
        chk("key_code", key_code, mcode);
        chk("multi_key", multi_key, $countones(m) > 1);
    endtask

    initial begin
        logic [3:0]  e;
        logic [15:0] m;
        int b1, n;
        rst  = 1'b1;
        keys = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_out", {col, key_code, key_valid, key_press, key_release, multi_key, frame_done},
            {4'b1110, 9'd0});
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            e = 4'b1110;
            repeat (k / 4) e = {e[2:0], e[3]};
            chk("col_walk", col, e);
            @(negedge clk);
        end
        step('0);

        repeat (3) step(kb(1, 1));
        repeat (3) step('0);

        repeat (2) step(kb(2, 2));
        step('0);
        repeat (3) step(kb(2, 2));
        repeat (3) step('0);

        repeat (3) step(kb(0, 0) | kb(0, 3));
        step('0);
        repeat (3) step(kb(0, 0));
        repeat (3) step(kb(0, 0) | kb(0, 1));
        repeat (3) step('0);

        repeat (3) step(kb(2, 3));
        step('0);
        #2 rst = 1'b1;
        #1 chk("rst_async", {col, key_code, key_valid, key_press, key_release, multi_key, frame_done},
               {4'b1110, 9'd0});
        model_reset();
        keys = kb(2, 3);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(kb(2, 3));
        repeat (3) step('0);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                repeat (3) step(kb(r, c));
                repeat (3) step('0);
            end

        n = 0;
        while (n < 150) begin
            b1 = $urandom_range(0, 9);
            m  = '0;
            if (b1 >= 3) m = 16'(1) << $urandom_range(0, 15);
            if (b1 >= 8) m = m | (16'(1) << ((low_idx(m) + $urandom_range(1, 15)) % 16));
            repeat ($urandom_range(1, 5)) begin
                step(m);
                n++;
            end
        end
        repeat (4) step('0);

        chk("press_total", press_seen, exp_press);
        chk("release_total", rel_seen, exp_rel);
        chk("stray_pulse", bad_pulse, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
